// File: rtl/rvvi_frame_sequencer.sv
// Buffers wide RVVI frames and streams each one as a header beat plus only the payload beats its CSR count needs.
// The header appears two cycles after valid is presented; beats hold while TxReady is low, and the core stalls near full.
module rvvi_frame_sequencer #(
   parameter int XLEN          = 64,
   parameter int MAX_CSRS      = 5,
   parameter int RVVI_WIDTH    = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
   parameter int CSR_COUNT_LSB = XLEN + 168,
   parameter int BEAT_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int STALL_MARGIN  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          Enable,
   input  logic                          valid,
   input  logic [RVVI_WIDTH-1:0]         rvvi,
   output logic                          TxValid,
   output logic [BEAT_WIDTH-1:0]         TxData,
   output logic                          TxLast,
   input  logic                          TxReady,
   output logic                          RVVIStall,
   output logic                          Overflow,
   output logic [$clog2(FIFO_DEPTH):0]   Occupancy
);

   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = $clog2(MAX_CSRS + 1);
   localparam int BASE_BITS = 72 + 5*XLEN;
   localparam int CSR_BITS  = XLEN + 16;
   localparam int MAX_BEATS = (BASE_BITS + MAX_CSRS*CSR_BITS + BEAT_WIDTH - 1) / BEAT_WIDTH;
   localparam int PAD_W     = MAX_BEATS * BEAT_WIDTH;

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

   function automatic int payload_bits(input int n);
      return BASE_BITS + n*CSR_BITS;
   endfunction

   function automatic int payload_beats(input int n);
      return (payload_bits(n) + BEAT_WIDTH - 1) / BEAT_WIDTH;
   endfunction

   // Per-CSR-count frame geometry, fixed at elaboration so no divider is built.
   logic [7:0]  beats_lut [MAX_CSRS+1];
   logic [15:0] bits_lut  [MAX_CSRS+1];
   for (genvar g = 0; g <= MAX_CSRS; g++) begin : g_lut
      assign beats_lut[g] = 8'(payload_beats(g));
      assign bits_lut[g]  = 16'(payload_bits(g));
   end

   logic [RVVI_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           occ, occ_next;
   logic                  full, push, pop, drop;

   state_t                state, state_n;
   logic [7:0]            beat_idx, beat_idx_n;
   logic [7:0]            last_idx, last_idx_n;
   logic [7:0]            total_lat, total_n;
   logic [15:0]           pbits_lat, pbits_n;
   logic [15:0]           seq, seq_n;

   logic [RVVI_WIDTH-1:0] head;
   logic [PAD_W-1:0]      head_pad;
   logic [11:0]           n_raw;
   logic [CW-1:0]         n_sel;
   logic [BEAT_WIDTH-1:0] beat_dat;

   assign head     = mem[rd_ptr];
   assign head_pad = PAD_W'(head);
   assign n_raw    = head[CSR_COUNT_LSB +: 12];
   assign n_sel    = (n_raw > 12'(MAX_CSRS)) ? CW'(MAX_CSRS) : CW'(n_raw);

   assign full = (occ == (AW+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot, so a full FIFO can still take a frame.
   assign push = valid && Enable && (!full || pop);
   assign drop = valid && Enable && full && !pop;

   always_comb begin
      unique case ({push, pop})
         2'b10:   occ_next = occ + (AW+1)'(1);
         2'b01:   occ_next = occ - (AW+1)'(1);
         default: occ_next = occ;
      endcase
   end

   // Payload bits past the frame's real length are forced to zero.
   always_comb begin
      beat_dat = head_pad[int'(beat_idx)*BEAT_WIDTH +: BEAT_WIDTH];
      for (int i = 0; i < BEAT_WIDTH; i++) begin
         if (int'(beat_idx)*BEAT_WIDTH + i >= int'(pbits_lat)) beat_dat[i] = 1'b0;
      end
   end

   always_comb begin
      state_n    = state;
      beat_idx_n = beat_idx;
      last_idx_n = last_idx;
      total_n    = total_lat;
      pbits_n    = pbits_lat;
      seq_n      = seq;
      TxValid    = 1'b0;
      TxLast     = 1'b0;
      TxData     = '0;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (occ != '0) begin
               state_n    = HEADER;
               last_idx_n = beats_lut[n_sel] - 8'd1;
               total_n    = beats_lut[n_sel] + 8'd1;
               pbits_n    = bits_lut[n_sel];
            end
         end
         HEADER: begin
            TxValid = 1'b1;
            TxData  = BEAT_WIDTH'({seq, total_lat, 8'hA5});
            if (TxReady) begin
               state_n    = PAYLOAD;
               beat_idx_n = '0;
            end
         end
         PAYLOAD: begin
            TxValid = 1'b1;
            TxData  = beat_dat;
            TxLast  = (beat_idx == last_idx);
            if (TxReady) begin
               if (beat_idx == last_idx) begin
                  pop     = 1'b1;
                  seq_n   = seq + 16'd1;
                  state_n = IDLE;
               end else begin
                  beat_idx_n = beat_idx + 8'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat_idx  <= '0;
         last_idx  <= '0;
         total_lat <= '0;
         pbits_lat <= '0;
         seq       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         RVVIStall <= 1'b0;
         Overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         beat_idx  <= beat_idx_n;
         last_idx  <= last_idx_n;
         total_lat <= total_n;
         pbits_lat <= pbits_n;
         seq       <= seq_n;
         occ       <= occ_next;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         RVVIStall <= Enable && ((FIFO_DEPTH - int'(occ_next)) <= STALL_MARGIN);
         if (drop) Overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rvvi;
   end

   assign Occupancy = occ;

endmodule

// File: tb/tb_rvvi_frame_sequencer.sv
// Directed bench for rvvi_frame_sequencer: frame lengths, header fields, padding, backpressure, stall, overflow, reset.
module tb_rvvi_frame_sequencer;

   localparam int RW   = 792;
   localparam int PADW = 800;

   logic          clk = 1'b0;
   logic          reset;
   logic          Enable;
   logic          valid;
   logic [RW-1:0] rvvi;
   logic          TxValid;
   logic [31:0]   TxData;
   logic          TxLast;
   logic          TxReady;
   logic          RVVIStall;
   logic          Overflow;
   logic [2:0]    Occupancy;

   int n_chk = 0;
   int n_err = 0;

   rvvi_frame_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .Enable    (Enable),
      .valid     (valid),
      .rvvi      (rvvi),
      .TxValid   (TxValid),
      .TxData    (TxData),
      .TxLast    (TxLast),
      .TxReady   (TxReady),
      .RVVIStall (RVVIStall),
      .Overflow  (Overflow),
      .Occupancy (Occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk_frame(input logic [11:0] cnt, input logic [7:0] tag);
      logic [PADW-1:0] p;
      for (int k = 0; k < 25; k++) p[k*32 +: 32] = {tag, 8'(k), 16'hBEEF ^ 16'(k*77)};
      p[232 +: 12] = cnt;
      return p[RW-1:0];
   endfunction

   function automatic logic [31:0] exp_beat(input logic [RW-1:0] f, input int n, input int total,
                                            input logic [15:0] seq, input int b);
      logic [PADW-1:0] p;
      logic [31:0]     r;
      int              pb;
      int              pos;
      if (b == 0) return {seq, 8'(total), 8'hA5};
      p  = PADW'(f);
      pb = 392 + 80*n;
      for (int i = 0; i < 32; i++) begin
         pos  = (b-1)*32 + i;
         r[i] = (pos < pb) ? p[pos] : 1'b0;
      end
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b1; valid = 1'b0; TxReady = 1'b0; Enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic push(input logic [RW-1:0] f);
      valid = 1'b1; rvvi = f;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic rx_frame(input logic [RW-1:0] f, input int n, input int total, input logic [15:0] seq,
                           input bit toggle, input int abort_at, input bit do_push, input logic [RW-1:0] pf,
                           output int waited, output logic [31:0] last_dat);
      int beat;
      int guard;
      bit acc;
      waited = 0; last_dat = '0;
      while (!TxValid && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!TxValid) chk("hdr_timeout", TxValid, 1);
      else begin
         beat = 0; guard = 0;
         while (beat < total && beat != abort_at && guard < 1000) begin
            TxReady = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("vld", TxValid, 1);
            chk($sformatf("dat%0d", beat), TxData, exp_beat(f, n, total, seq, beat));
            chk("last", TxLast, beat == total-1);
            acc = TxValid && TxReady;
            if (acc && beat == total-1) begin
               last_dat = TxData;
               if (do_push) begin valid = 1'b1; rvvi = pf; end
            end
            @(posedge clk); #1;
            valid = 1'b0;
            if (acc) beat++;
            guard++;
         end
         if (guard >= 1000) chk("beat_timeout", beat, total);
      end
   endtask

   task automatic rx(input logic [RW-1:0] f, input int n, input int total, input logic [15:0] seq);
      int          w;
      logic [31:0] d;
      rx_frame(f, n, total, seq, 1'b0, -1, 1'b0, '0, w, d);
   endtask

   initial begin
      int            w;
      logic [31:0]   d;
      logic [RW-1:0] fr [5];

      reset = 1'b1; Enable = 1'b1; valid = 1'b0; rvvi = '0; TxReady = 1'b0;
      do_reset();
      chk("rst_vld",   TxValid, 0);
      chk("rst_dat",   TxData, 0);
      chk("rst_last",  TxLast, 0);
      chk("rst_stall", RVVIStall, 0);
      chk("rst_ovf",   Overflow, 0);
      chk("rst_occ",   Occupancy, 0);

      // CSR count 0: 14 beats, last beat carries only 8 valid bits
      fr[0] = mk_frame(12'd0, 8'h10);
      push(fr[0]);
      chk("occ_push1", Occupancy, 1);
      chk("idle_push1", TxValid, 0);
      chk("stall_push1", RVVIStall, 0);
      rx_frame(fr[0], 0, 14, 16'd0, 1'b0, -1, 1'b0, '0, w, d);
      chk("latency", w, 1);
      chk("b13_pad", d[31:8], 0);
      chk("occ_drained", Occupancy, 0);
      fr[1] = mk_frame(12'd0, 8'h11);
      push(fr[1]);
      rx(fr[1], 0, 14, 16'd1);

      // CSR counts 2 then 5 back to back, then clamped count 7
      do_reset();
      fr[0] = mk_frame(12'd2, 8'h20);
      fr[1] = mk_frame(12'd5, 8'h21);
      push(fr[0]);
      push(fr[1]);
      rx(fr[0], 2, 19, 16'd0);
      rx_frame(fr[1], 5, 26, 16'd1, 1'b0, -1, 1'b0, '0, w, d);
      chk("b2b_idle", w, 1);
      fr[2] = mk_frame(12'd7, 8'h22);
      push(fr[2]);
      rx_frame(fr[2], 5, 26, 16'd2, 1'b0, -1, 1'b0, '0, w, d);
      chk("clamp_pad", d[31:24], 0);

      // Fill with TxReady low: stall, overflow, ordered drain
      do_reset();
      for (int i = 0; i < 4; i++) begin
         fr[i] = mk_frame(12'd1, 8'h30 + 8'(i));
         push(fr[i]);
         if (i == 0) chk("stall_1", RVVIStall, 0);
         if (i == 1) chk("stall_2", RVVIStall, 1);
      end
      chk("occ_full", Occupancy, 4);
      chk("ovf_before", Overflow, 0);
      push(mk_frame(12'd1, 8'h3F));
      chk("ovf_set", Overflow, 1);
      chk("occ_ovf", Occupancy, 4);
      rx(fr[0], 1, 16, 16'd0);
      chk("stall_occ3", RVVIStall, 1);
      rx(fr[1], 1, 16, 16'd1);
      chk("stall_occ2", RVVIStall, 1);
      rx(fr[2], 1, 16, 16'd2);
      chk("stall_occ1", RVVIStall, 0);
      rx(fr[3], 1, 16, 16'd3);
      chk("ovf_sticky", Overflow, 1);
      chk("occ_empty", Occupancy, 0);

      // Push coinciding with the final accept while full, then Enable drop
      do_reset();
      for (int i = 0; i < 5; i++) fr[i] = mk_frame(12'd0, 8'h40 + 8'(i));
      for (int i = 0; i < 4; i++) push(fr[i]);
      rx_frame(fr[0], 0, 14, 16'd0, 1'b0, -1, 1'b1, fr[4], w, d);
      chk("ovf_coincide", Overflow, 0);
      chk("occ_coincide", Occupancy, 4);
      TxReady = 1'b0;
      Enable  = 1'b0;
      push(mk_frame(12'd0, 8'h4F));
      chk("dis_occ", Occupancy, 4);
      chk("dis_stall", RVVIStall, 0);
      chk("dis_ovf", Overflow, 0);
      for (int i = 1; i < 5; i++) rx(fr[i], 0, 14, 16'(i));
      chk("dis_drained", Occupancy, 0);

      // Random backpressure, then reset in the middle of a frame
      do_reset();
      fr[0] = mk_frame(12'd0, 8'h50);
      fr[1] = mk_frame(12'd5, 8'h51);
      push(fr[0]);
      rx(fr[0], 0, 14, 16'd0);
      push(fr[1]);
      rx_frame(fr[1], 5, 26, 16'd1, 1'b1, 7, 1'b0, '0, w, d);
      do_reset();
      chk("mid_vld",   TxValid, 0);
      chk("mid_dat",   TxData, 0);
      chk("mid_last",  TxLast, 0);
      chk("mid_occ",   Occupancy, 0);
      chk("mid_stall", RVVIStall, 0);
      fr[2] = mk_frame(12'd0, 8'h52);
      push(fr[2]);
      rx(fr[2], 0, 14, 16'd0);

      // Enable low discards frames outright
      Enable = 1'b0;
      push(mk_frame(12'd3, 8'h60));
      chk("en0_occ", Occupancy, 0);
      @(posedge clk); #1;
      chk("en0_vld", TxValid, 0);
      chk("en0_stall", RVVIStall, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
